io_port_unit: RTL and testbench
===============================

Name: io_port_unit

Overview:
- Responder for the processor's IN/OUT instructions, driven by the memory-stage IOE/IOR/IOW control bits.
- Buffers device-to-CPU words in an input FIFO and CPU-to-device words in an output FIFO, each with a valid/ready handshake on the device side.
- Stalls the pipeline while a request cannot be served.
- Aborts a request with an error flag after a bounded wait, so the pipeline never hangs.

Parameters:
- WIDTH, 16, data word width for both directions.
- IN_DEPTH, 4, input FIFO entries (power of two, >=2).
- OUT_DEPTH, 4, output FIFO entries (power of two, >=2).
- TIMEOUT, 16, consecutive stalled cycles before a request is aborted (>=2).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- io_en  in  1  I/O access this cycle (IOE).
- io_rd  in  1  IN request: pop the input FIFO.
- io_wr  in  1  OUT request: push to the output FIFO.
- io_wdata  in  WIDTH  OUT data.
- io_rdata  out  WIDTH  IN data; combinational from the input FIFO head.
- io_stall  out  1  hold the pipeline; request not completed this cycle.
- in_valid  in  1  device presents in_data.
- in_data  in  WIDTH  device word.
- in_ready  out  1  input FIFO not full.
- out_valid  out  1  output FIFO not empty.
- out_data  out  WIDTH  output FIFO head.
- out_ready  in  1  device accepts out_data.
- timeout_err  out  1  sticky: a request was aborted.
- proto_err  out  1  sticky: io_rd and io_wr were asserted together.

Behaviour:
- Reset, synchronous and active-high:
  - Both FIFOs empty, pointers and counts 0.
  - FSM in IDLE, wait counter 0.
  - Both error flags 0.
  - Outputs: io_rdata=0, io_stall=0, in_ready=1, out_valid=0, out_data=0.
  - Reset mid-stall discards the pending request and all buffered data.
- FIFOs:
  - Show-ahead; count width clog2(DEPTH)+1; pointers wrap modulo DEPTH.
  - Full/empty use the count before the edge. There is no same-cycle bypass: a push into a full FIFO is refused even if a pop occurs in the same cycle.
  - Device push: in_valid & in_ready.
  - Device pop: out_valid & out_ready.
  - Simultaneous push and pop on a non-full, non-empty FIFO leaves the count unchanged.
- Request decode, when io_en=1:
  - rd only: serviceable iff the input FIFO is non-empty.
  - wr only: serviceable iff the output FIFO is not full.
  - rd & wr: set proto_err; treat as rd only, write dropped.
  - io_en=0: no request; io_rd and io_wr are ignored.
- Serviceable request:
  - io_stall=0 and io_rdata = input FIFO head in the same cycle.
  - The pop or push takes effect at that clock edge; latency 0 for the CPU.
- io_rdata = 0 whenever no read is being serviced.
- FSM states IDLE, WAIT, ABORT:
  - IDLE: an unserviceable request asserts io_stall and loads counter=1, then -> WAIT. A serviceable request or no request stays in IDLE.
  - WAIT:
    - io_stall=1 while the request remains unserviceable; counter increments.
    - Becomes serviceable: complete as above, io_stall=0, -> IDLE.
    - io_en drops: -> IDLE, no action.
    - Counter reaches TIMEOUT while still unserviceable: -> ABORT.
  - ABORT, exactly one cycle:
    - io_stall=0, no FIFO action on the CPU side; read returns all-ones, write is dropped.
    - Set timeout_err; -> IDLE, counter=0.
  - The device-side handshakes continue in every state.
- Stall length: at most TIMEOUT cycles of io_stall=1 per request.
- Error flags clear only on reset.

Test Plan:
- Reset, then device pushes 16'h1234, 16'hABCD; CPU rd twice -> io_rdata 1234 then ABCD, io_stall=0, in_ready=1 throughout.
- CPU wr 4 words with out_ready=0 -> out_valid=1, out_data=first word. 5th wr -> io_stall=1. Raise out_ready one cycle -> stall drops the next cycle and the 5th word is accepted.
- CPU rd on empty input FIFO, device silent -> io_stall=1 for exactly 16 cycles, then one cycle of io_rdata=16'hFFFF with io_stall=0, timeout_err=1 and held.
- CPU rd on empty input FIFO; device pushes 16'h0055 at stall cycle 3 -> io_rdata=0055 on the following cycle, io_stall=0, timeout_err stays 0.
- io_rd=io_wr=1 with input FIFO holding 16'h0007 -> read returns 0007, output FIFO unchanged, proto_err=1.
- Fill input FIFO (in_ready=0), assert reset during a pending wr stall -> next cycle in_ready=1, out_valid=0, io_stall=0, both flags 0.

Source files
------------

// File: rtl/io_port_unit.sv
// I/O port responder for IN/OUT instructions: input and output FIFOs toward the device,
// pipeline stall while a request waits, and a bounded wait that aborts with an error flag.
//
// state | meaning
// IDLE  | no pending request; serviceable requests complete with zero latency
// WAIT  | request pending and stalled; wait counter running
// ABORT | one-cycle abort: read returns all-ones, write dropped, timeout_err set
module io_port_unit #(
    parameter int WIDTH     = 16,
    parameter int IN_DEPTH  = 4,
    parameter int OUT_DEPTH = 4,
    parameter int TIMEOUT   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             io_en,
    input  logic             io_rd,
    input  logic             io_wr,
    input  logic [WIDTH-1:0] io_wdata,
    output logic [WIDTH-1:0] io_rdata,
    output logic             io_stall,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             timeout_err,
    output logic             proto_err
);

    localparam int IN_AW  = $clog2(IN_DEPTH);
    localparam int OUT_AW = $clog2(OUT_DEPTH);
    localparam int TW     = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ABORT} state_e;

    state_e            state_q, state_d;
    logic [TW-1:0]     cnt_q, cnt_d;
    logic              timeout_err_q, timeout_err_d;
    logic              proto_err_q, proto_err_d;

    logic [WIDTH-1:0]  in_mem_q [IN_DEPTH];
    logic [WIDTH-1:0]  in_mem_d [IN_DEPTH];
    logic [IN_AW-1:0]  in_wptr_q, in_wptr_d, in_rptr_q, in_rptr_d;
    logic [IN_AW:0]    in_cnt_q, in_cnt_d;

    logic [WIDTH-1:0]  out_mem_q [OUT_DEPTH];
    logic [WIDTH-1:0]  out_mem_d [OUT_DEPTH];
    logic [OUT_AW-1:0] out_wptr_q, out_wptr_d, out_rptr_q, out_rptr_d;
    logic [OUT_AW:0]   out_cnt_q, out_cnt_d;

    logic in_empty, in_full, out_empty, out_full;
    logic in_push, in_pop, out_push, out_pop;
    logic req, req_rd, req_wr, serv;
    logic [WIDTH-1:0] in_head;

    assign in_empty  = (in_cnt_q == '0);
    assign in_full   = (in_cnt_q == (IN_AW + 1)'(IN_DEPTH));
    assign out_empty = (out_cnt_q == '0);
    assign out_full  = (out_cnt_q == (OUT_AW + 1)'(OUT_DEPTH));

    assign in_ready  = ~in_full;
    assign out_valid = ~out_empty;
    assign in_head   = in_mem_q[in_rptr_q];
    assign out_data  = out_empty ? '0 : out_mem_q[out_rptr_q];

    assign in_push = in_valid & in_ready;
    assign out_pop = out_valid & out_ready;

    // Simultaneous rd & wr is treated as a read; the write is dropped.
    assign req    = io_en & (io_rd | io_wr);
    assign req_rd = io_en & io_rd;
    assign req_wr = io_en & io_wr & ~io_rd;
    assign serv   = req_rd ? ~in_empty : (req_wr & ~out_full);

    // FSM: state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_WAIT: begin
                if (!req || serv) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == TW'(TIMEOUT - 1)) begin
                    state_d = S_ABORT;
                    cnt_d   = TW'(TIMEOUT);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_ABORT: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: begin
                if (req && !serv) begin
                    state_d = S_WAIT;
                    cnt_d   = TW'(1);
                end
            end
        endcase
    end

    // FSM: outputs
    always_comb begin
        io_stall = 1'b0;
        io_rdata = '0;
        in_pop   = 1'b0;
        out_push = 1'b0;
        case (state_q)
            S_ABORT: begin
                if (req_rd) io_rdata = '1;
            end
            default: begin
                if (req) begin
                    if (serv) begin
                        in_pop   = req_rd;
                        out_push = req_wr;
                        if (req_rd) io_rdata = in_head;
                    end else begin
                        io_stall = 1'b1;
                    end
                end
            end
        endcase
    end

    always_comb begin
        in_mem_d  = in_mem_q;
        in_wptr_d = in_wptr_q;
        in_rptr_d = in_rptr_q;
        in_cnt_d  = in_cnt_q;
        if (in_push) begin
            in_mem_d[in_wptr_q] = in_data;
            in_wptr_d = in_wptr_q + 1'b1;
        end
        if (in_pop) in_rptr_d = in_rptr_q + 1'b1;
        case ({in_push, in_pop})
            2'b10:   in_cnt_d = in_cnt_q + 1'b1;
            2'b01:   in_cnt_d = in_cnt_q - 1'b1;
            default: in_cnt_d = in_cnt_q;
        endcase
    end

    always_comb begin
        out_mem_d  = out_mem_q;
        out_wptr_d = out_wptr_q;
        out_rptr_d = out_rptr_q;
        out_cnt_d  = out_cnt_q;
        if (out_push) begin
            out_mem_d[out_wptr_q] = io_wdata;
            out_wptr_d = out_wptr_q + 1'b1;
        end
        if (out_pop) out_rptr_d = out_rptr_q + 1'b1;
        case ({out_push, out_pop})
            2'b10:   out_cnt_d = out_cnt_q + 1'b1;
            2'b01:   out_cnt_d = out_cnt_q - 1'b1;
            default: out_cnt_d = out_cnt_q;
        endcase
    end

    always_comb begin
        timeout_err_d = timeout_err_q | (state_q == S_ABORT);
        proto_err_d   = proto_err_q | (io_en & io_rd & io_wr);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < IN_DEPTH; i++) in_mem_q[i] <= '0;
            for (int i = 0; i < OUT_DEPTH; i++) out_mem_q[i] <= '0;
            in_wptr_q     <= '0;
            in_rptr_q     <= '0;
            in_cnt_q      <= '0;
            out_wptr_q    <= '0;
            out_rptr_q    <= '0;
            out_cnt_q     <= '0;
            timeout_err_q <= 1'b0;
            proto_err_q   <= 1'b0;
        end else begin
            in_mem_q      <= in_mem_d;
            out_mem_q     <= out_mem_d;
            in_wptr_q     <= in_wptr_d;
            in_rptr_q     <= in_rptr_d;
            in_cnt_q      <= in_cnt_d;
            out_wptr_q    <= out_wptr_d;
            out_rptr_q    <= out_rptr_d;
            out_cnt_q     <= out_cnt_d;
            timeout_err_q <= timeout_err_d;
            proto_err_q   <= proto_err_d;
        end
    end

    assign timeout_err = timeout_err_q;
    assign proto_err   = proto_err_q;

endmodule

// File: tb/tb_io_port_unit.sv
// Directed bench for io_port_unit: inputs change just after the falling edge,
// outputs are checked 1 ns later, well away from the rising edge.
module tb_io_port_unit;

    logic        clk;
    logic        reset;
    logic        io_en, io_rd, io_wr;
    logic [15:0] io_wdata, io_rdata;
    logic        io_stall;
    logic        in_valid, in_ready;
    logic [15:0] in_data;
    logic        out_valid, out_ready;
    logic [15:0] out_data;
    logic        timeout_err, proto_err;

    int n_cmp = 0;
    int n_err = 0;

    io_port_unit #(.WIDTH(16), .IN_DEPTH(4), .OUT_DEPTH(4), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset),
        .io_en(io_en), .io_rd(io_rd), .io_wr(io_wr),
        .io_wdata(io_wdata), .io_rdata(io_rdata), .io_stall(io_stall),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .timeout_err(timeout_err), .proto_err(proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; io_en = 1'b0; io_rd = 1'b0; io_wr = 1'b0; io_wdata = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_rdata", io_rdata, 0);
        chk("rst_stall", io_stall, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_timeout_err", timeout_err, 0);
        chk("rst_proto_err", proto_err, 0);

        // device pushes two words, CPU reads them back
        @(negedge clk); in_valid = 1'b1; in_data = 16'h1234; #1;
        chk("t1_in_ready0", in_ready, 1);
        @(negedge clk); in_data = 16'hABCD; #1;
        chk("t1_in_ready1", in_ready, 1);
        @(negedge clk); in_valid = 1'b0; io_en = 1'b1; io_rd = 1'b1; #1;
        chk("t1_rd0_data", io_rdata, 16'h1234);
        chk("t1_rd0_stall", io_stall, 0);
        @(negedge clk); #1;
        chk("t1_rd1_data", io_rdata, 16'hABCD);
        chk("t1_rd1_stall", io_stall, 0);
        chk("t1_in_ready2", in_ready, 1);
        @(negedge clk); io_en = 1'b0; io_rd = 1'b0; #1;
        chk("t1_idle_rdata", io_rdata, 0);

        // CPU fills the output FIFO, fifth write stalls until the device drains one
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); io_en = 1'b1; io_wr = 1'b1; io_wdata = 16'(16'h1111 * (i + 1)); #1;
            chk("t2_wr_stall", io_stall, 0);
        end
        @(negedge clk); io_wdata = 16'h5555; #1;
        chk("t2_full_stall", io_stall, 1);
        chk("t2_out_valid", out_valid, 1);
        chk("t2_out_data", out_data, 16'h1111);
        @(negedge clk); out_ready = 1'b1; #1;
        chk("t2_drain_stall", io_stall, 1);
        @(negedge clk); out_ready = 1'b0; #1;
        chk("t2_accept_stall", io_stall, 0);
        @(negedge clk); io_en = 1'b0; io_wr = 1'b0; #1;
        chk("t2_head_after", out_data, 16'h2222);
        chk("t2_valid_after", out_valid, 1);

        // read on empty input FIFO, device delivers during the third stall cycle
        @(negedge clk); io_en = 1'b1; io_rd = 1'b1; #1;
        chk("t4_stall_c1", io_stall, 1);
        @(negedge clk); #1;
        chk("t4_stall_c2", io_stall, 1);
        @(negedge clk); in_valid = 1'b1; in_data = 16'h0055; #1;
        chk("t4_stall_c3", io_stall, 1);
        @(negedge clk); in_valid = 1'b0; #1;
        chk("t4_rdata", io_rdata, 16'h0055);
        chk("t4_stall_done", io_stall, 0);
        @(negedge clk); io_en = 1'b0; io_rd = 1'b0; #1;
        chk("t4_timeout_err", timeout_err, 0);
        chk("t4_idle_stall", io_stall, 0);

        // simultaneous rd & wr: read wins, write dropped, proto_err set
        @(negedge clk); in_valid = 1'b1; in_data = 16'h0007;
        @(negedge clk); in_valid = 1'b0; io_en = 1'b1; io_rd = 1'b1; io_wr = 1'b1;
        io_wdata = 16'h9999; #1;
        chk("t5_rdata", io_rdata, 16'h0007);
        chk("t5_stall", io_stall, 0);
        @(negedge clk); io_en = 1'b0; io_rd = 1'b0; io_wr = 1'b0; #1;
        chk("t5_proto_err", proto_err, 1);
        chk("t5_out_data", out_data, 16'h2222);
        chk("t5_out_valid", out_valid, 1);
        chk("t5_idle_rdata", io_rdata, 0);

        // read on empty FIFO with silent device: 16 stall cycles then abort
        @(negedge clk); io_en = 1'b1; io_rd = 1'b1; #1;
        chk("t3_stall_1", io_stall, 1);
        for (int i = 2; i <= 16; i++) begin
            @(negedge clk); #1;
            chk("t3_stall_n", io_stall, 1);
        end
        @(negedge clk); #1;
        chk("t3_abort_stall", io_stall, 0);
        chk("t3_abort_rdata", io_rdata, 16'hFFFF);
        @(negedge clk); io_en = 1'b0; io_rd = 1'b0; #1;
        chk("t3_timeout_err", timeout_err, 1);
        repeat (3) @(negedge clk);
        #1;
        chk("t3_timeout_held", timeout_err, 1);
        chk("t3_idle_stall", io_stall, 0);

        // fill input FIFO, stall a write on the full output FIFO, then reset
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); in_valid = 1'b1; in_data = 16'(16'h00A0 + i);
        end
        @(negedge clk); in_valid = 1'b0; #1;
        chk("t6_in_full", in_ready, 0);
        io_en = 1'b1; io_wr = 1'b1; io_wdata = 16'h6666; #1;
        chk("t6_wr_stall0", io_stall, 1);
        @(negedge clk); #1;
        chk("t6_wr_stall1", io_stall, 1);
        @(negedge clk); reset = 1'b1; io_en = 1'b0; io_wr = 1'b0;
        @(negedge clk); reset = 1'b0; #1;
        chk("t6_in_ready", in_ready, 1);
        chk("t6_out_valid", out_valid, 0);
        chk("t6_out_data", out_data, 0);
        chk("t6_stall", io_stall, 0);
        chk("t6_timeout_err", timeout_err, 0);
        chk("t6_proto_err", proto_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
